// File: rtl/mm_dma.sv
`default_nettype none
// ============================================================================
//  Module   : mm_dma
//  Purpose  : Word-granular memory-to-memory copy engine. Programmed through a
//             small register slave port; moves LEN words from SRC to DST as
//             alternating read/write beats on a valid/ready master port and
//             reports completion through DONE and an optional level IRQ.
//  Ports    : clk, reset (async, active-high)
//             slave  : select, wstrb, addr, data_i -> ready, data_o
//             master : m_valid, m_addr, m_wdata, m_wstrb <- m_ready, m_rdata
//             irq    : DONE & IE, registered
//  Config   : MM_DMA_IRQ_EN - when defined, the IE bit is stored and irq is
//             driven; otherwise IE reads 0 and irq is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module mm_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [3:0]  addr,
    input  logic [31:0] data_i,
    output logic        ready,
    output logic [31:0] data_o,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        irq
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rd   = 2'd1;
    localparam logic [1:0] c_st_wr   = 2'd2;

    localparam logic [1:0] c_reg_src  = 2'd0;
    localparam logic [1:0] c_reg_dst  = 2'd1;
    localparam logic [1:0] c_reg_len  = 2'd2;
    localparam logic [1:0] c_reg_ctrl = 2'd3;

    logic [1:0]           r_state;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [LEN_WIDTH-1:0] r_len;
    logic [31:0]          r_buf;
    logic                 r_done;
    logic                 r_aborted;
    logic                 r_abort_pend;
    logic                 r_served;
    logic                 r_ready;
    logic [31:0]          r_data_o;
    logic                 r_m_valid;
    logic [31:0]          r_m_addr;
    logic [31:0]          r_m_wdata;
    logic [3:0]           r_m_wstrb;

    logic                 w_acc;
    logic                 w_wr;
    logic                 w_ctrl_wr;
    logic                 w_busy;
    logic                 w_abort;
    logic                 w_ie;
    logic [31:0]          w_len32;
    logic [31:0]          w_status;
    logic [31:0]          w_rdmux;
    logic                 w_unused;

    // Only the register index bits of the byte address matter.
    assign w_unused = ^addr[1:0];

    // One access per select assertion: r_served blocks a second ready until
    // select has been seen low.
    assign w_acc     = select && !r_served;
    assign w_wr      = w_acc && (wstrb != 4'd0);
    assign w_ctrl_wr = w_wr && (addr[3:2] == c_reg_ctrl) && wstrb[0];
    assign w_busy    = (r_state != c_st_idle);
    // An ABORT arriving on the same edge as the beat handshake still counts.
    assign w_abort   = r_abort_pend || (w_ctrl_wr && data_i[1]);

    always_comb begin
        w_len32                = '0;
        w_len32[LEN_WIDTH-1:0] = r_len;
    end

    assign w_status = {28'd0, r_aborted, w_ie, r_done, w_busy};

    always_comb begin
        w_rdmux = '0;
        case (addr[3:2])
            c_reg_src: w_rdmux = r_src;
            c_reg_dst: w_rdmux = r_dst;
            c_reg_len: w_rdmux = w_len32;
            default:   w_rdmux = w_status;
        endcase
    end

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_buf        <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_served     <= 1'b0;
            r_ready      <= 1'b0;
            r_data_o     <= '0;
            r_m_valid    <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_m_wstrb    <= '0;
        end else begin
            // Slave handshake: one-cycle ready, read data only in that cycle.
            r_ready  <= w_acc;
            r_data_o <= w_acc ? w_rdmux : 32'd0;
            if (!select) begin
                r_served <= 1'b0;
            end else if (w_acc) begin
                r_served <= 1'b1;
            end

            // Address/length registers are frozen while a copy runs.
            if (w_wr && !w_busy) begin
                case (addr[3:2])
                    c_reg_src: r_src <= f_merge(r_src, data_i, wstrb) & 32'hFFFF_FFFC;
                    c_reg_dst: r_dst <= f_merge(r_dst, data_i, wstrb) & 32'hFFFF_FFFC;
                    c_reg_len: begin
                        for (int i = 0; i < LEN_WIDTH; i++) begin
                            if (wstrb[i/8]) r_len[i] <= data_i[i];
                        end
                    end
                    default: ;
                endcase
            end

            if (w_ctrl_wr && data_i[3]) begin
                r_done    <= 1'b0;
                r_aborted <= 1'b0;
            end

            if (w_ctrl_wr && data_i[1] && w_busy) begin
                r_abort_pend <= 1'b1;
            end

            // Engine. Placed after the register-write logic so that a DONE
            // set on the same edge as a write-1-clear takes priority.
            case (r_state)
                c_st_idle: begin
                    if (w_ctrl_wr && data_i[0]) begin
                        r_done    <= 1'b0;
                        r_aborted <= 1'b0;
                        if (r_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state   <= c_st_rd;
                            r_m_valid <= 1'b1;
                            r_m_addr  <= r_src;
                            r_m_wstrb <= 4'h0;
                        end
                    end
                end

                c_st_rd: begin
                    if (!r_m_valid) begin
                        // Gap cycle over: issue the read beat.
                        r_m_valid <= 1'b1;
                        r_m_addr  <= r_src;
                        r_m_wstrb <= 4'h0;
                    end else if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_buf     <= m_rdata;
                        r_src     <= r_src + 32'd4;
                        if (w_abort) begin
                            r_state      <= c_st_idle;
                            r_aborted    <= 1'b1;
                            r_abort_pend <= 1'b0;
                        end else begin
                            r_state <= c_st_wr;
                        end
                    end
                end

                c_st_wr: begin
                    if (!r_m_valid) begin
                        r_m_valid <= 1'b1;
                        r_m_addr  <= r_dst;
                        r_m_wdata <= r_buf;
                        r_m_wstrb <= 4'hF;
                    end else if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_dst     <= r_dst + 32'd4;
                        r_len     <= r_len - LEN_WIDTH'(1);
                        if (w_abort) begin
                            r_state      <= c_st_idle;
                            r_aborted    <= 1'b1;
                            r_abort_pend <= 1'b0;
                        end else if (r_len == LEN_WIDTH'(1)) begin
                            r_state <= c_st_idle;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_st_rd;
                        end
                    end
                end

                default: begin
                    r_state   <= c_st_idle;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MM_DMA_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ie <= data_i[2];
            r_irq <= r_done && r_ie;
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    assign w_ie = 1'b0;
    assign irq  = 1'b0;
`endif

    assign ready   = r_ready;
    assign data_o  = r_data_o;
    assign m_valid = r_m_valid;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wstrb = r_m_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mm_dma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mm_dma
//  Purpose  : Directed self-checking bench for mm_dma. A behavioural memory
//             slave with programmable wait states answers the master port;
//             source words are a fixed function of the address.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mm_dma;

`ifdef MM_DMA_IRQ_EN
    localparam logic c_ie = 1'b1;
`else
    localparam logic c_ie = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        select = 1'b0;
    logic [3:0]  wstrb  = 4'd0;
    logic [3:0]  addr   = 4'd0;
    logic [31:0] data_i = 32'd0;
    logic        ready;
    logic [31:0] data_o;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory slave model state (written only by the always block below).
    int          wait_cfg = 0;
    int          wcnt     = 0;
    int          cyc      = 0;
    int          beat_cnt = 0;
    int          vld_cnt  = 0;
    int          stab_err = 0;
    logic        p_pend   = 1'b0;
    logic [31:0] p_addr   = 32'd0;
    logic [31:0] p_wdata  = 32'd0;
    logic [3:0]  p_strb   = 4'd0;
    logic [31:0] wmem    [0:1023];
    logic [31:0] log_addr[0:127];
    logic        log_wr  [0:127];
    int          log_cyc [0:127];

    mm_dma #(.LEN_WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .select  (select),
        .wstrb   (wstrb),
        .addr    (addr),
        .data_i  (data_i),
        .ready   (ready),
        .data_o  (data_o),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Source pattern: word n of the 0x2_0000 region holds 0x11*(n+1).
    function automatic logic [31:0] src_word(input logic [31:0] a);
        return 32'h11 * ({24'd0, a[9:2]} + 32'd1);
    endfunction

    assign m_ready = m_valid && (wcnt >= wait_cfg);
    assign m_rdata = src_word(m_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            wcnt   <= 0;
            p_pend <= 1'b0;
        end else begin
            if (m_valid && !m_ready) wcnt <= wcnt + 1;
            else                     wcnt <= 0;
            if (m_valid) vld_cnt <= vld_cnt + 1;
            if (p_pend && m_valid &&
                (m_addr != p_addr || m_wdata != p_wdata || m_wstrb != p_strb))
                stab_err <= stab_err + 1;
            p_pend  <= m_valid && !m_ready;
            p_addr  <= m_addr;
            p_wdata <= m_wdata;
            p_strb  <= m_wstrb;
            if (m_valid && m_ready && beat_cnt < 128) begin
                log_addr[beat_cnt] <= m_addr;
                log_wr[beat_cnt]   <= (m_wstrb == 4'hF);
                log_cyc[beat_cnt]  <= cyc;
                if (m_wstrb == 4'hF) wmem[m_addr[11:2]] <= m_wdata;
                beat_cnt <= beat_cnt + 1;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reg_access(input logic [3:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] q);
        int n;
        @(negedge clk);
        select = 1'b1; addr = a; wstrb = s; data_i = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 8);
        if (!ready) check_value("slave_ready", {31'd0, ready}, 32'd1);
        q = data_o;
        select = 1'b0; wstrb = 4'd0;
    endtask

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] q;
        reg_access(a, d, 4'hF, q);
    endtask

    task automatic reg_chk(input string tag, input logic [3:0] a,
                           input logic [31:0] exp);
        logic [31:0] q;
        reg_access(a, 32'd0, 4'h0, q);
        check_value(tag, q, exp);
    endtask

    task automatic wait_beats(input string tag, input int target, input int maxcyc);
        int n;
        n = 0;
        while (beat_cnt < target && n < maxcyc) begin
            @(negedge clk);
            n++;
        end
        check_value(tag, beat_cnt, target);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   n;
        logic [31:0] q;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_value("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_value("rst_m_addr", m_addr, 32'd0);
        check_value("rst_ready", {31'd0, ready}, 32'd0);
        check_value("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_value("rst_data_o", data_o, 32'd0);
        reg_chk("rst_status", 4'hC, 32'd0);
        reg_chk("rst_len", 4'h8, 32'd0);

        // ---------------- byte strobes and forced alignment ----------------
        reg_access(4'h0, 32'hFFFF_FFFF, 4'b0101, q);
        reg_chk("src_strb", 4'h0, 32'h00FF_00FC);
        @(negedge clk);
        check_value("ready_pulse", {31'd0, ready}, 32'd0);

        // ---------------- 4-word copy, zero wait ----------------
        wait_cfg = 0;
        base = beat_cnt;
        reg_wr(4'h0, 32'h0002_0000);
        reg_wr(4'h4, 32'h0002_0100);
        reg_wr(4'h8, 32'd4);
        reg_wr(4'hC, 32'h1);
        wait_beats("cp_beats", base + 8, 200);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_value("cp_rd_seq", log_addr[base+2*i] | {31'd0, log_wr[base+2*i]},
                        32'h0002_0000 + 32'(4*i));
            check_value("cp_wr_seq", log_addr[base+2*i+1] | {31'd0, log_wr[base+2*i+1]},
                        32'h0002_0101 + 32'(4*i));
            check_value("cp_data", wmem[64+i], 32'h11 * 32'(i+1));
        end
        check_value("cp_cycles", log_cyc[base+7] - log_cyc[base], 32'd14);
        reg_chk("cp_status", 4'hC, 32'h2);
        reg_chk("cp_src", 4'h0, 32'h0002_0010);
        reg_chk("cp_dst", 4'h4, 32'h0002_0110);
        reg_chk("cp_len", 4'h8, 32'd0);
        check_value("cp_irq_off", {31'd0, irq}, 32'd0);

        // ABORT in IDLE has no effect
        reg_wr(4'hC, 32'h2);
        reg_chk("idle_abort", 4'hC, 32'h2);

        // ---------------- 3-cycle wait-state slave ----------------
        wait_cfg = 3;
        base = beat_cnt;
        n = stab_err;
        reg_wr(4'h0, 32'h0002_0000);
        reg_wr(4'h4, 32'h0002_0200);
        reg_wr(4'h8, 32'd3);
        reg_wr(4'hC, 32'h1);
        wait_beats("ws_beats", base + 6, 400);
        repeat (20) @(negedge clk);
        check_value("ws_no_dup", beat_cnt, base + 6);
        check_value("ws_stable", stab_err, n);
        for (int i = 0; i < 3; i++)
            check_value("ws_data", wmem[128+i], 32'h11 * 32'(i+1));
        reg_chk("ws_status", 4'hC, 32'h2);

        // ---------------- LEN=0 start ----------------
        n = vld_cnt;
        reg_wr(4'hC, 32'h8);
        reg_chk("z_cleared", 4'hC, 32'h0);
        reg_wr(4'hC, 32'h5);
        reg_chk("z_status", 4'hC, {29'd0, c_ie, 2'b10});
        check_value("z_irq", {31'd0, irq}, {31'd0, c_ie});
        check_value("z_no_bus", vld_cnt, n);
        reg_wr(4'hC, 32'h8);
        repeat (2) @(negedge clk);
        check_value("z_irq_clr", {31'd0, irq}, 32'd0);

        // ---------------- ABORT during 3rd RD beat ----------------
        wait_cfg = 3;
        base = beat_cnt;
        reg_wr(4'h0, 32'h0002_0000);
        reg_wr(4'h4, 32'h0002_0300);
        reg_wr(4'h8, 32'd8);
        reg_wr(4'hC, 32'h1);
        n = 0;
        while (!(beat_cnt == base + 4 && m_valid && m_wstrb == 4'h0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value("ab_reach_rd3", beat_cnt, base + 4);
        reg_wr(4'hC, 32'h2);
        repeat (30) @(negedge clk);
        check_value("ab_beats", beat_cnt, base + 5);
        check_value("ab_last_rd", log_addr[base+4] | {31'd0, log_wr[base+4]}, 32'h0002_0008);
        reg_chk("ab_status", 4'hC, 32'h8);
        reg_chk("ab_len", 4'h8, 32'd6);
        reg_chk("ab_src", 4'h0, 32'h0002_000C);
        reg_chk("ab_dst", 4'h4, 32'h0002_0308);

        // ---------------- writes and START while busy ----------------
        wait_cfg = 1;
        base = beat_cnt;
        reg_wr(4'h0, 32'h0002_0000);
        reg_wr(4'h4, 32'h0002_0400);
        reg_wr(4'h8, 32'd3);
        reg_wr(4'hC, 32'h1);
        reg_wr(4'h0, 32'h0002_0800);
        reg_wr(4'h8, 32'h10);
        reg_wr(4'hC, 32'h1);
        wait_beats("bw_beats", base + 6, 300);
        repeat (20) @(negedge clk);
        check_value("bw_no_extra", beat_cnt, base + 6);
        for (int i = 0; i < 3; i++)
            check_value("bw_data", wmem[256+i], 32'h11 * 32'(i+1));
        reg_chk("bw_len", 4'h8, 32'd0);
        reg_chk("bw_src", 4'h0, 32'h0002_000C);
        reg_chk("bw_dst", 4'h4, 32'h0002_040C);
        reg_chk("bw_status", 4'hC, 32'h2);

        // ---------------- reset during a stalled WR beat ----------------
        wait_cfg = 20;
        reg_wr(4'h0, 32'h0002_0000);
        reg_wr(4'h4, 32'h0002_0500);
        reg_wr(4'h8, 32'd2);
        reg_wr(4'hC, 32'h5);
        n = 0;
        while (!(m_valid && m_wstrb == 4'hF) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value("rw_in_wr", {28'd0, m_wstrb}, 32'hF);
        #1 reset = 1'b1;
        #1 check_value("rw_valid_drop", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_cfg = 0;
        @(negedge clk);
        check_value("rw_m_addr", m_addr, 32'd0);
        check_value("rw_m_wstrb", {28'd0, m_wstrb}, 32'd0);
        reg_chk("rw_src", 4'h0, 32'd0);
        reg_chk("rw_dst", 4'h4, 32'd0);
        reg_chk("rw_len", 4'h8, 32'd0);
        reg_chk("rw_status", 4'hC, 32'd0);
        check_value("rw_irq", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mm_dma.md
# mm_dma

Word-granular memory-to-memory copy engine for the picoRV SoC. It is a bus initiator on the same native valid/ready memory bus the CPU drives, so it drives valid/addr/wdata/wstrb and waits for ready. It is also a register slave, so the CPU programs it like the systick and LED peripherals. It sits beside the CPU behind a 2-master arbiter (outside this block), with its slave port decoded at 0x8000_0200–0x8000_020F, and signals completion on an IRQ line.

## Interface
Parameters:
- LEN_WIDTH, 16, width of the word-count register (max transfer 2^LEN_WIDTH−1 words)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- select  in  1  slave port selected (address decoded, mem_valid qualified)
- wstrb  in  4  slave write strobes; 0 = read
- addr  in  4  slave byte address; bits [3:2] pick register
- data_i  in  32  slave write data
- ready  out  1  slave access complete
- data_o  out  32  slave read data
- m_valid  out  1  master request valid
- m_addr  out  32  master word address, bits [1:0] always 0
- m_wdata  out  32  master write data
- m_wstrb  out  4  master strobes: 4'b0000 read, 4'b1111 write
- m_ready  in  1  master transfer accepted/complete
- m_rdata  in  32  master read data, valid when m_ready=1
- irq  out  1  level interrupt: DONE & IE

## Operation
- Registers:
  - 0x0 SRC: source word address
  - 0x4 DST: destination word address
  - 0x8 LEN: words remaining
  - 0xC CTRL/STATUS
- SRC/DST/LEN are writable only in IDLE. Writes while busy are ignored. Writes force bits [1:0] of SRC/DST to 0. Reads return live values.
- A slave write applies only bytes with their wstrb bit set.
- CTRL write bits:
  - bit0 START
  - bit1 ABORT
  - bit2 IE (stored)
  - bit3 write-1-clears DONE and ABORTED
- STATUS read bits: bit0 BUSY, bit1 DONE, bit2 IE, bit3 ABORTED; other bits read 0.
- FSM states: IDLE, RD, WR.
  - IDLE + START, LEN≠0 → RD. Clears DONE and ABORTED.
  - IDLE + START, LEN=0 → stays IDLE. Sets DONE. No bus traffic.
  - RD: m_valid=1, m_addr=SRC, m_wstrb=0. On m_ready, latch m_rdata into the data buffer, SRC+=4 → WR.
  - WR: m_valid=1, m_addr=DST, m_wdata=buffer, m_wstrb=4'hF. On m_ready, DST+=4, LEN−=1. If LEN becomes 0 → IDLE and set DONE; else → RD.
- ABORT while busy: latched, then acted on at the next m_ready. Either beat may be in flight (RD or WR). The engine returns to IDLE, sets ABORTED, leaves DONE=0, and keeps SRC/DST/LEN at their current values. A completed RD beat under ABORT performs no write. ABORT in IDLE is ignored.
- START while busy is ignored.
- SRC/DST increments wrap modulo 2^32.
- BUSY = (state ≠ IDLE).

## Timing
- Reset (async): state IDLE, all registers 0, IE=0. Outputs m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, ready=0, data_o=0, irq=0.
- Reset asserted mid-transfer drops m_valid in the same cycle, with no handshake completion.
- Slave port: ready is registered, high for exactly one cycle the cycle after select rises. It does not re-assert until select has been low for a cycle.
  - Register write takes effect at the ready edge.
  - data_o is valid in the ready cycle and is 0 otherwise.
- Master port: all master outputs are registered. m_valid rises the cycle after START is written.
  - m_addr/m_wdata/m_wstrb stay stable while m_valid=1 and m_ready=0.
  - A beat completes in the cycle m_ready=1. m_valid then drops for exactly one cycle before the next beat.
- Minimum per word: 4 cycles with zero-wait slaves (RD beat, gap, WR beat, gap).
- DONE sets in the cycle after the final WR m_ready. irq follows one cycle later, registered.
- Simultaneous slave write-1-clear of DONE and a DONE set: the set wins.

## Configuration
- MM_DMA_IRQ_EN defined: IE bit stored and readable; irq = registered DONE & IE.
- MM_DMA_IRQ_EN undefined: no IE flop; IE reads 0; irq tied 0. DONE polling is unchanged.

## Test plan
- Copy 4 words, SRC=0x2_0000 (0x11,0x22,0x33,0x44), DST=0x2_0100, zero-wait slave → DST holds the same data. Master sequence is RD,WR ×4 with exact addresses. STATUS=0x2 at end; SRC=0x2_0010, DST=0x2_0110, LEN=0.
- Slave with 3-cycle m_ready delay → m_addr/m_wdata stable through the waits; data copied correctly; no duplicate beats.
- LEN=0 then START → zero m_valid cycles; DONE=1 the next cycle; irq=1 with IE=1 (when MM_DMA_IRQ_EN is defined).
- LEN=8, ABORT during the 3rd RD beat → that RD completes, no 3rd write. STATUS=0x8, LEN=6, SRC advanced by 12, DST advanced by 8.
- Write SRC/LEN and a second START mid-transfer → ignored; transfer completes with the original length.
- Assert reset during a WR beat with m_ready low → m_valid=0 immediately; all registers read 0 after reset release.
